xor_swap_sequencer: RTL and testbench

- Sequences the XOR-swap datapath (A^=B; B^=A; A^=B) over a small internal register file, with no temporary storage.
- A host writes and reads registers, then requests a swap of two addressed entries through a ready/req/done handshake.
- The block serialises the three XOR steps, guards the same-address hazard, and blocks host writes while a swap is in flight.

---
 rtl/swap_pkg.sv | 16 +
 rtl/xor_swap_regfile.sv | 39 +++
 rtl/xor_swap_sequencer.sv | 114 +++++++++++
 tb/tb_xor_swap_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/swap_pkg.sv
// Shared types and default sizes for the XOR-swap sequencer.
package swap_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned COUNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_XOR1 = 3'd1,
        ST_XOR2 = 3'd2,
        ST_XOR3 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/xor_swap_regfile.sv
// DEPTH x WIDTH register file: one synchronous write port, one host read port
// and two operand read ports, all reads combinational.
module xor_swap_regfile
    import swap_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data_c,
    input  logic [AW-1:0]    op_addr_a,
    input  logic [AW-1:0]    op_addr_b,
    output logic [WIDTH-1:0] op_a_c,
    output logic [WIDTH-1:0] op_b_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data_c = mem[rd_addr];
    assign op_a_c    = mem[op_addr_a];
    assign op_b_c    = mem[op_addr_b];

endmodule

// File: rtl/xor_swap_sequencer.sv
// Serialises A^=B; B^=A; A^=B over two latched regfile entries, with a
// same-address bypass and host-write blocking while a swap is in flight.
module xor_swap_sequencer
    import swap_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    input  logic               swap_req,
    input  logic [AW-1:0]      swap_addr_a,
    input  logic [AW-1:0]      swap_addr_b,
    output logic               swap_ready,
    output logic               swap_done,
    output logic               wr_err,
    output logic [COUNT_W-1:0] swap_count
);

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    addr_a_q;
    logic [AW-1:0]    addr_b_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;

    xor_swap_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .rd_addr   (rd_addr),
        .rd_data_c (rd_data),
        .op_addr_a (addr_a_q),
        .op_addr_b (addr_b_q),
        .op_a_c    (op_a),
        .op_b_c    (op_b)
    );

    // Next state and the single regfile write of each step.
    always_comb begin
        state_nx = state;
        rf_we    = 1'b0;
        rf_waddr = wr_addr;
        rf_wdata = wr_data;
        unique case (state)
            ST_IDLE: begin
                rf_we = wr_en;
                if (swap_req) begin
                    state_nx = (swap_addr_a != swap_addr_b) ? ST_XOR1 : ST_DONE;
                end
            end
            ST_XOR1: begin
                rf_we    = 1'b1;
                rf_waddr = addr_a_q;
                rf_wdata = op_a ^ op_b;
                state_nx = ST_XOR2;
            end
            ST_XOR2: begin
                rf_we    = 1'b1;
                rf_waddr = addr_b_q;
                rf_wdata = op_a ^ op_b;
                state_nx = ST_XOR3;
            end
            ST_XOR3: begin
                rf_we    = 1'b1;
                rf_waddr = addr_a_q;
                rf_wdata = op_a ^ op_b;
                state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            swap_ready <= 1'b1;
            swap_done  <= 1'b0;
            wr_err     <= 1'b0;
            swap_count <= '0;
        end else begin
            state      <= state_nx;
            swap_ready <= (state_nx == ST_IDLE);
            swap_done  <= (state_nx == ST_DONE);
            wr_err     <= wr_en && (state != ST_IDLE);
            if (state == ST_IDLE && swap_req) begin
                addr_a_q <= swap_addr_a;
                addr_b_q <= swap_addr_b;
            end
            if (state_nx == ST_DONE && swap_count != '1) begin
                swap_count <= swap_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xor_swap_sequencer.sv
// Self-checking bench for xor_swap_sequencer: vector table of swaps plus
// hand-written busy-write, simultaneous-write, back-to-back and reset cases.
module tb_xor_swap_sequencer;
    import swap_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          swap_req;
    logic [AW-1:0] swap_addr_a;
    logic [AW-1:0] swap_addr_b;
    logic          swap_ready;
    logic          swap_done;
    logic          wr_err;
    logic [15:0]   swap_count;

    always #5 clk = ~clk;

    xor_swap_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .swap_req    (swap_req),
        .swap_addr_a (swap_addr_a),
        .swap_addr_b (swap_addr_b),
        .swap_ready  (swap_ready),
        .swap_done   (swap_done),
        .wr_err      (wr_err),
        .swap_count  (swap_count)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [W-1:0]  va;
        logic [W-1:0]  vb;
        logic [W-1:0]  exp_a;
        logic [W-1:0]  exp_b;
        int            lat;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [W-1:0]  exp_a;
        logic [W-1:0]  exp_b;
        int            lat;
    } sb_t;

    sb_t  sb[$];
    vec_t vt[6];
    int   total = 0;
    int   bad = 0;
    int   cnt_exp = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_chk(input string nm, input logic [AW-1:0] a, input logic [W-1:0] exp);
        rd_addr = a;
        #1;
        check(nm, 32'(rd_data), 32'(exp));
    endtask

    // Drives a request through acceptance edge E0 and records the expected result.
    task automatic start_swap(input logic [AW-1:0] a, input logic [AW-1:0] b,
                              input logic [W-1:0] ea, input logic [W-1:0] eb,
                              input int lat, input bit hold);
        check("ready_before_req", 32'(swap_ready), 32'd1);
        swap_req    = 1'b1;
        swap_addr_a = a;
        swap_addr_b = b;
        sb.push_back('{a, b, ea, eb, lat});
        tick();
        wr_en = 1'b0;
        if (!hold) begin
            swap_req    = 1'b0;
            swap_addr_a = AW'($urandom);
            swap_addr_b = AW'($urandom);
        end
    endtask

    // n0 = edges already taken since (and including) E0.
    task automatic wait_done(input int n0);
        int  n;
        sb_t e;
        n = n0;
        while (!swap_done && n < 16) begin
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("done_latency", 32'(n), 32'(e.lat));
            read_chk("result_a", e.a, e.exp_a);
            read_chk("result_b", e.b, e.exp_b);
            cnt_exp++;
            tick();
            check("swap_count", 32'(swap_count), 32'(cnt_exp));
            check("ready_after", 32'(swap_ready), 32'd1);
            check("done_one_cycle", 32'(swap_done), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        swap_req = 1'b0; swap_addr_a = '0; swap_addr_b = '0;

        vt[0] = '{3'd2, 3'd5, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 4};
        vt[1] = '{3'd3, 3'd3, 8'h77, 8'h77, 8'h77, 8'h77, 1};
        vt[2] = '{3'd0, 3'd1, 8'hFF, 8'h00, 8'h00, 8'hFF, 4};
        vt[3] = '{3'd6, 3'd7, 8'h00, 8'hFF, 8'hFF, 8'h00, 4};
        vt[4] = '{3'd4, 3'd4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1};
        vt[5] = '{3'd1, 3'd6, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4};

        tick();
        tick();
        rst = 1'b0;

        check("rst_ready", 32'(swap_ready), 32'd1);
        check("rst_done", 32'(swap_done), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        check("rst_count", 32'(swap_count), 32'd0);
        read_chk("rst_reg0", 3'd0, 8'h00);

        for (int i = 0; i < 6; i++) begin
            host_write(vt[i].a, vt[i].va);
            if (vt[i].a != vt[i].b) host_write(vt[i].b, vt[i].vb);
            start_swap(vt[i].a, vt[i].b, vt[i].exp_a, vt[i].exp_b, vt[i].lat, 1'b0);
            wait_done(1);
        end

        // Write while busy: reg2=3C, reg5=A5, reg0=00 at this point.
        start_swap(3'd2, 3'd5, 8'hA5, 8'h3C, 4, 1'b0);
        tick();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        check("wr_err_idle_low", 32'(wr_err), 32'd0);
        tick();
        wr_en = 1'b0;
        check("wr_err_pulse", 32'(wr_err), 32'd1);
        wait_done(3);
        check("wr_err_clear", 32'(wr_err), 32'd0);
        read_chk("busy_write_dropped", 3'd0, 8'h00);

        // Write and swap in the same IDLE cycle.
        host_write(3'd4, 8'hF0);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h0F;
        start_swap(3'd1, 3'd4, 8'hF0, 8'h0F, 4, 1'b0);
        wait_done(1);

        // Back-to-back with swap_req held high.
        host_write(3'd0, 8'h11);
        host_write(3'd7, 8'h22);
        start_swap(3'd0, 3'd7, 8'h22, 8'h11, 4, 1'b1);
        wait_done(1);
        sb.push_back('{3'd0, 3'd7, 8'h11, 8'h22, 4});
        tick();
        wait_done(1);
        swap_req = 1'b0;
        check("b2b_count", 32'(swap_count), 32'(cnt_exp));

        // Reset during XOR2.
        host_write(3'd3, 8'hAB);
        swap_req = 1'b1; swap_addr_a = 3'd3; swap_addr_b = 3'd5;
        tick();
        swap_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt_exp = 0;
        check("midrst_ready", 32'(swap_ready), 32'd1);
        check("midrst_count", 32'(swap_count), 32'd0);
        for (int k = 0; k < 6; k++) begin
            check("midrst_no_done", 32'(swap_done), 32'd0);
            tick();
        end
        for (int k = 0; k < int'(D); k++) begin
            read_chk("midrst_reg_zero", AW'(k), 8'h00);
        end
        check("midrst_count_hold", 32'(swap_count), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
